// File: rtl/imm_pkg.sv
// Shared opcode constants, output format codes and skid-buffer state encoding
// for the immediate decode stage.
package imm_pkg;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/decode_imm_stage_if.sv
// Handshake and result bundle of the immediate decode stage; slave is the
// stage's own view, master is the surrounding pipeline's view.
interface decode_imm_stage_if
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  fmt_e             out_fmt;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_cnt;
  logic             cnt_clr;

  modport slave (
    input  in_valid, in_instr, out_ready, cnt_clr,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, illegal_cnt
  );

  modport master (
    output in_valid, in_instr, out_ready, cnt_clr,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, illegal_cnt
  );

endinterface

// File: rtl/imm_extract.sv
// Combinational RV immediate extraction and format classification.
// Define IMM_ZICSR_EN to decode SYSTEM (csr) immediates; otherwise SYSTEM is illegal.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [31:0] imm32;

  // Every format is first built as a 32-bit value; widening to XLEN is a pure sign extension.
  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  always_comb begin
    imm32   = '0;
    fmt     = FMT_NONE;
    illegal = 1'b1;
    case (instr[6:0])
      OP_IMM, OP_LOAD, OP_JALR: begin
        imm32   = {{20{instr[31]}}, instr[31:20]};
        fmt     = FMT_I;
        illegal = 1'b0;
      end
      OP_STORE: begin
        imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        fmt     = FMT_S;
        illegal = 1'b0;
      end
      OP_BRANCH: begin
        imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        fmt     = FMT_B;
        illegal = 1'b0;
      end
      OP_LUI, OP_AUIPC: begin
        imm32   = {instr[31:12], 12'b0};
        fmt     = FMT_U;
        illegal = 1'b0;
      end
      OP_JAL: begin
        imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        fmt     = FMT_J;
        illegal = 1'b0;
      end
      OP_OP: begin
        illegal = 1'b0;
      end
`ifdef IMM_ZICSR_EN
      OP_SYSTEM: begin
        illegal = 1'b0;
        if (instr[14:12] inside {3'b101, 3'b110, 3'b111}) begin
          imm32 = {27'b0, instr[19:15]};
          fmt   = FMT_Z;
        end else begin
          imm32 = {20'b0, instr[31:20]};
          fmt   = FMT_I;
        end
      end
`endif
      default: ;
    endcase
  end

  assign imm = sext32($signed(imm32));

endmodule

// File: rtl/decode_imm_stage.sv
// Immediate decode stage: imm_extract feeding a 2-entry skid buffer (main + skid
// register) with a registered in_ready, plus a saturating illegal-opcode counter.
module decode_imm_stage
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  decode_imm_stage_if.slave   bus
);

  state_e           state_q, state_d;
  logic             in_ready_q;
  logic [XLEN-1:0]  main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
  fmt_e             main_fmt_q, main_fmt_d, skid_fmt_q, skid_fmt_d;
  logic             main_ill_q, main_ill_d, skid_ill_q, skid_ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0]  ext_imm;
  fmt_e             ext_fmt;
  logic             ext_ill;
  logic             in_fire, out_fire;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr   (bus.in_instr),
    .imm     (ext_imm),
    .fmt     (ext_fmt),
    .illegal (ext_ill)
  );

  assign in_fire  = bus.in_valid && in_ready_q;
  assign out_fire = (state_q != ST_EMPTY) && bus.out_ready;

  always_comb begin
    state_d    = state_q;
    main_imm_d = main_imm_q;
    main_fmt_d = main_fmt_q;
    main_ill_d = main_ill_q;
    skid_imm_d = skid_imm_q;
    skid_fmt_d = skid_fmt_q;
    skid_ill_d = skid_ill_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_imm_d = ext_imm;
          main_fmt_d = ext_fmt;
          main_ill_d = ext_ill;
          state_d    = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_imm_d = ext_imm;
          main_fmt_d = ext_fmt;
          main_ill_d = ext_ill;
        end else if (in_fire) begin
          // Downstream stalled: park the new result so main stays stable.
          skid_imm_d = ext_imm;
          skid_fmt_d = ext_fmt;
          skid_ill_d = ext_ill;
          state_d    = ST_FULL;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          main_imm_d = skid_imm_q;
          main_fmt_d = skid_fmt_q;
          main_ill_d = skid_ill_q;
          state_d    = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (in_fire && ext_ill && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_imm_q <= '0;
      main_fmt_q <= FMT_NONE;
      main_ill_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
      main_imm_q <= main_imm_d;
      main_fmt_q <= main_fmt_d;
      main_ill_q <= main_ill_d;
      cnt_q      <= cnt_d;
    end
  end

  // Skid contents are only observed after a FULL transition, so they need no reset.
  always_ff @(posedge clk) begin
    skid_imm_q <= skid_imm_d;
    skid_fmt_q <= skid_fmt_d;
    skid_ill_q <= skid_ill_d;
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = (state_q != ST_EMPTY);
  assign bus.out_imm     = main_imm_q;
  assign bus.out_fmt     = main_fmt_q;
  assign bus.out_illegal = main_ill_q;
  assign bus.illegal_cnt = cnt_q;

endmodule

// File: doc/decode_imm_stage.md
DECODE_IMM_STAGE -- requirements
Module: decode_imm_stage

Interface
REQ-001 Parameter XLEN, default 32, meaning datapath/immediate width; legal values 32 or 64.
REQ-002 Parameter CNT_W, default 16, meaning illegal-opcode counter width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream instruction valid.
REQ-006 in_ready  output  1  stage can accept an instruction this cycle.
REQ-007 in_instr  input  32  raw RV instruction word.
REQ-008 out_valid  output  1  registered result valid.
REQ-009 out_ready  input  1  downstream accepts result this cycle.
REQ-010 out_imm  output  XLEN  sign/zero-extended immediate.
REQ-011 out_fmt  output  3  format code: NONE, I, S, B, U, J, Z.
REQ-012 out_illegal  output  1  opcode not recognised.
REQ-013 illegal_cnt  output  CNT_W  saturating count of illegal instructions accepted.
REQ-014 cnt_clr  input  1  synchronous clear of illegal_cnt.

Function
REQ-015 Transfer occurs on in_valid&&in_ready (input) and out_valid&&out_ready (output).
REQ-016 Latency: accepted instruction appears on outputs the next cycle when the output register is free.
REQ-017 Stage SHALL be a 2-entry skid buffer: main output register plus one skid register; no bubble at full throughput.
REQ-018 States: EMPTY (out_valid=0), ONE (main valid, skid empty), FULL (both valid).
REQ-019 Transitions: EMPTY->ONE on input; ONE->FULL on input with !out_ready; ONE->EMPTY on output with no input; FULL->ONE on output (skid moves to main).
REQ-020 ONE with simultaneous input and output SHALL stay ONE, main loading the new result.
REQ-021 in_ready SHALL be registered and equal to (state!=FULL).
REQ-022 While out_valid&&!out_ready, out_imm/out_fmt/out_illegal SHALL hold stable.
REQ-023 I-format (opcodes 0010011, 0000011, 1100111): sign-extend instr[31:20] to XLEN.
REQ-024 S-format (0100011): sign-extend {instr[31:25],instr[11:7]}.
REQ-025 B-format (1100011): sign-extend {instr[31],instr[7],instr[30:25],instr[11:8],0}.
REQ-026 U-format (0110111, 0010111): {instr[31:12],12'b0}, sign-extended from bit 31 when XLEN=64.
REQ-027 J-format (1101111): sign-extend {instr[31],instr[19:12],instr[20],instr[30:21],0}.
REQ-028 Opcode 0110011 (R-type): fmt NONE, imm 0, illegal 0.
REQ-029 Any other opcode: fmt NONE, imm 0, illegal 1.
REQ-030 illegal_cnt SHALL increment once per accepted illegal instruction and saturate at all-ones.
REQ-031 cnt_clr SHALL take priority over a same-cycle increment; result 0.

Reset
REQ-032 rst SHALL force state EMPTY, out_valid=0, in_ready=1, out_imm=0, out_fmt=NONE, out_illegal=0, illegal_cnt=0.
REQ-033 rst mid-operation SHALL discard both buffered entries; an input presented in the reset cycle is not accepted.

Configuration
REQ-034 Macro IMM_ZICSR_EN: when defined, opcode 1110011 with funct3 in {101,110,111} yields fmt Z, imm = zero-extended instr[19:15], illegal 0; other funct3 under 1110011 yield fmt I, imm = zero-extended instr[31:20].
REQ-035 Without IMM_ZICSR_EN, opcode 1110011 SHALL be treated per REQ-029.

Structure
REQ-036 Package imm_pkg SHALL hold opcode constants and the out_fmt enumerated type.
REQ-037 Combinational extraction SHALL live in sub-module imm_extract (instr, XLEN in; imm, fmt, illegal out); decode_imm_stage holds the skid buffer and counter.

Verification
REQ-038 XLEN=32, send 0xFFF00093 (addi -1) -> next cycle out_imm=0xFFFFFFFF, fmt I, illegal 0.
REQ-039 Send 0xFE000FE3 (beq -2) -> out_imm=0xFFFFFFFE, fmt B; send 0x12345037 -> 0x12345000, fmt U.
REQ-040 XLEN=64, send 0x800000B7 (lui) -> out_imm=0xFFFFFFFF80000000.
REQ-041 Hold out_ready=0, push 3 back-to-back instructions -> 2 accepted, in_ready=0 on third; release -> both emerge in order, no loss/duplication.
REQ-042 Push opcode 0x7F with illegal_cnt preset to max -> out_illegal=1, counter stays max; cnt_clr -> 0.
REQ-043 With IMM_ZICSR_EN, send 0x34015073 (csrrwi) -> out_imm=0x2, fmt Z; without macro -> illegal 1.
